sha256_digest_unpacker: RTL

Output-side companion to the SHA-256 core. It takes one completed 256-bit digest through the core's valid/yumi output handshake (`v_o` / `yumi_i` on the core side). It then streams the digest as eight 32-bit words over a ready/valid word interface toward the FSB return path. One digest is buffered internally. Digests can be taken back-to-back with no bubble, so the core is released as soon as its result is captured.

---
 rtl/sha256_digest_unpacker.sv | 50 +++++
 1 files changed

// File: rtl/sha256_digest_unpacker.sv
// sha256_digest_unpacker: buffers one 256-bit digest and streams it as eight 32-bit words
module sha256_digest_unpacker #(
  parameter int MSW_FIRST = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             v_i,
  input  logic [255:0]     digest_i,
  output logic             yumi_o,
  output logic             v_o,
  output logic [31:0]      data_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] digest_cnt_o
);
  typedef enum logic {eEmpty, eSend} state_e;
  state_e state_r;
  logic [255:0] buf_r;
  logic [2:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic xfer, at_last;
  logic [2:0] sel;
  assign at_last = idx_r == 3'd7;
  assign v_o = state_r == eSend;
  assign xfer = v_o & ready_i;
  // a new digest may be taken in the very cycle the previous one's last word leaves
  assign yumi_o = ~reset_i & en_i & v_i & (~v_o | (xfer & at_last));
  assign sel = (MSW_FIRST != 0) ? 3'd7 - idx_r : idx_r;
  assign data_o = v_o ? buf_r[{sel, 5'd0} +: 32] : 32'd0;
  assign last_o = v_o & at_last;
  assign digest_cnt_o = cnt_r;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eEmpty;
      buf_r <= '0;
      idx_r <= '0;
      cnt_r <= '0;
    end else begin
      if (yumi_o) begin
        buf_r <= digest_i;
        idx_r <= '0;
        state_r <= eSend;
      end else if (xfer & at_last) state_r <= eEmpty;
      else if (xfer) idx_r <= idx_r + 3'd1;
      if (xfer & at_last) cnt_r <= cnt_r + 1'b1;
    end
  end
endmodule
